// File: rtl/biquad_incremental_pipe.sv
// biquad_incremental_pipe: frame-parallel incremental biquad stage.
// For each frame of NSAMP samples, y[2..NSAMP-1] are computed one sample per pipeline
// stage from the externally supplied y[0], y[1]. Coefficients move through a shadow chain,
// a checked load FSM, a pending bank and per-stage active banks. The per-stage active banks
// are loaded one stage per cycle, so every frame sees exactly one coefficient set.
// Optional feature: define BIQUAD_INC_SAT_EN to saturate each y[k] sum and the output
// slice. The default build wraps.
// Assumes NBITS + (NFRAC2 - NFRAC) <= NBITS2, so a scaled x[k] fits one internal word.
module biquad_incremental_pipe #(
  parameter int unsigned NSAMP  = 8,
  parameter int unsigned NBITS  = 16,
  parameter int unsigned NFRAC  = 2,
  parameter int unsigned NBITS2 = 24,
  parameter int unsigned NFRAC2 = 10,
  parameter int unsigned CBITS  = 18,
  parameter int unsigned CFRAC  = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NBITS*NSAMP-1:0] dat_i,
  input  logic [NBITS2-1:0]      y0_in,
  input  logic [NBITS2-1:0]      y1_in,
  input  logic                   valid_i,
  output logic [NBITS*NSAMP-1:0] dat_o,
  output logic                   valid_o,
  input  logic [CBITS-1:0]       coeff_dat_i,
  input  logic                   coeff_wr_i,
  input  logic                   coeff_update_i,
  output logic                   coeff_ack_o,
  output logic                   coeff_err_o,
  input  logic                   coeff_err_clr_i
);

  localparam int unsigned NCOEF = 2 * (NSAMP - 2);
  localparam int unsigned NSTG  = NSAMP - 2;      // recurrence stages, k = 2..NSAMP-1
  localparam int unsigned NPIPE = NSAMP - 1;      // capture stage + recurrence stages
  localparam int unsigned SHX   = NFRAC2 - NFRAC; // x -> internal alignment shift
  localparam int unsigned PW    = NBITS2 + CBITS; // exact product width
  localparam int unsigned SW    = PW + 2;         // three-term sum without overflow
  localparam int unsigned CW    = $clog2(NCOEF + 1);
  localparam logic [CW-1:0] CntFull = CW'(NCOEF);

  typedef logic signed [NBITS2-1:0] yw_t;
  typedef logic signed [CBITS-1:0]  coef_t;
  typedef enum logic [1:0] {StIdle, StLoading, StReady} ld_state_e;

  // ---------------------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------------------

  function automatic yw_t scale_x(input logic [NBITS-1:0] x);
    yw_t xe;
    xe = NBITS2'($signed(x));
    return xe <<< SHX;
  endfunction

  // y = xs + floor(c1*ym1 / 2^CFRAC) + floor(c2*ym2 / 2^CFRAC), reduced to NBITS2 bits
  function automatic yw_t rec_step(input yw_t xs, input yw_t ym1, input yw_t ym2,
                                   input coef_t c1, input coef_t c2);
    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] p2;
    logic signed [SW-1:0] sum;
    p1  = PW'(c1) * PW'(ym1);
    p2  = PW'(c2) * PW'(ym2);
    sum = SW'(xs) + SW'(p1 >>> CFRAC) + SW'(p2 >>> CFRAC);
`ifdef BIQUAD_INC_SAT_EN
    if (sum[SW-1:NBITS2-1] != {(SW-NBITS2+1){sum[SW-1]}}) begin
      return sum[SW-1] ? {1'b1, {(NBITS2-1){1'b0}}} : {1'b0, {(NBITS2-1){1'b1}}};
    end
    return sum[NBITS2-1:0];
`else
    return sum[NBITS2-1:0];
`endif
  endfunction

  function automatic logic [NBITS-1:0] out_slice(input yw_t y);
`ifdef BIQUAD_INC_SAT_EN
    yw_t t;
    t = y >>> SHX;
    if (t[NBITS2-1:NBITS-1] != {(NBITS2-NBITS+1){t[NBITS2-1]}}) begin
      return t[NBITS2-1] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
    end
    return t[NBITS-1:0];
`else
    return y[SHX +: NBITS];
`endif
  endfunction

  // ---------------------------------------------------------------------------------------
  // Coefficient path
  // ---------------------------------------------------------------------------------------

  coef_t     shadow_q  [NCOEF];
  coef_t     pending_q [NCOEF];
  coef_t     act_c1_q  [NSTG];
  coef_t     act_c2_q  [NSTG];
  ld_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic          ack_q;
  logic          err_q;
  logic [NSTG-2:0] swap_dly_q;
  logic [NSTG-1:0] swap_tok;

  assign coeff_ack_o = ack_q;
  assign coeff_err_o = err_q;

  // Shadow chain: newest word enters at index 0, so after NCOEF writes shadow[m] holds m.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NCOEF; j++) shadow_q[j] <= '0;
    end else if (coeff_wr_i) begin
      shadow_q[0] <= coeff_dat_i;
      for (int j = 1; j < NCOEF; j++) shadow_q[j] <= shadow_q[j-1];
    end
  end

  // Load FSM: counts writes, checks update requests, commits shadow to pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int j = 0; j < NCOEF; j++) pending_q[j] <= '0;
    end else begin
      ack_q <= 1'b0;
      if (coeff_err_clr_i) err_q <= 1'b0;
      if (coeff_update_i) begin
        // The update is judged on the pre-write state; a new error overrides the clear.
        if (state_q == StReady) begin
          ack_q <= 1'b1;
          for (int j = 0; j < NCOEF; j++) pending_q[j] <= shadow_q[j];
        end else begin
          err_q <= 1'b1;
        end
        if (coeff_wr_i) begin
          cnt_q   <= CW'(1);
          state_q <= StLoading;
        end else begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      end else if (coeff_wr_i) begin
        if (cnt_q != CntFull) begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CntFull - 1'b1) ? StReady : StLoading;
        end
      end
    end
  end

  // Token for stage k = j+2 fires at edge U+k-1; ack_q itself is the stage-2 token.
  assign swap_tok = {swap_dly_q, ack_q};

  // Per-stage delayed commit from pending into each stage's active bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_dly_q <= '0;
      for (int j = 0; j < NSTG; j++) begin
        act_c1_q[j] <= '0;
        act_c2_q[j] <= '0;
      end
    end else begin
      swap_dly_q <= swap_tok[NSTG-2:0];
      for (int j = 0; j < NSTG; j++) begin
        if (swap_tok[j]) begin
          act_c1_q[j] <= pending_q[2*j];
          act_c2_q[j] <= pending_q[2*j+1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Sample pipeline
  // ---------------------------------------------------------------------------------------

  // Stage s holds y[0..s+1] in final form and scaled x[k] in the slots k > s+1.
  yw_t y_q [NPIPE][NSAMP];
  yw_t y_d [NPIPE][NSAMP];
  logic [NPIPE-1:0] vld_q;

  // x[0] and x[1] are replaced by the supplied y[0] and y[1].
  logic unused_x01;
  assign unused_x01 = ^dat_i[2*NBITS-1:0];

  // Stage s computes y[s+1] from y[s], y[s-1] of the previous stage.
  always_comb begin
    y_d[0][0] = y0_in;
    y_d[0][1] = y1_in;
    for (int k = 2; k < NSAMP; k++) y_d[0][k] = scale_x(dat_i[NBITS*k +: NBITS]);
    for (int s = 1; s < NPIPE; s++) begin
      y_d[s]      = y_q[s-1];
      y_d[s][s+1] = rec_step(y_q[s-1][s+1], y_q[s-1][s], y_q[s-1][s-1],
                             act_c1_q[s-1], act_c2_q[s-1]);
    end
  end

  // Pipeline registers; frames advance every cycle regardless of valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < NPIPE; s++) begin
        for (int k = 0; k < NSAMP; k++) y_q[s][k] <= '0;
      end
    end else begin
      vld_q <= {vld_q[NPIPE-2:0], valid_i};
      for (int s = 0; s < NPIPE; s++) y_q[s] <= y_d[s];
    end
  end

  // Output register: slice each internal y[k] back to the sample format.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= vld_q[NPIPE-1];
      for (int k = 0; k < NSAMP; k++) dat_o[NBITS*k +: NBITS] <= out_slice(y_q[NPIPE-1][k]);
    end
  end

endmodule

// File: tb/tb_biquad_incremental_pipe.sv
// Directed bench for biquad_incremental_pipe at default parameters (NSAMP = 8).
// Expected values are hand-computed constants; BIQUAD_INC_SAT_EN selects the overflow case.
module tb_biquad_incremental_pipe;

  localparam int NSAMP  = 8;
  localparam int NBITS  = 16;
  localparam int NBITS2 = 24;
  localparam int CBITS  = 18;
  localparam int NCOEF  = 2 * (NSAMP - 2);
  localparam int DW     = NBITS * NSAMP;
  localparam logic [CBITS-1:0] ONE = 18'd16384;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW-1:0]     dat_i = '0;
  logic [NBITS2-1:0] y0_in = '0;
  logic [NBITS2-1:0] y1_in = '0;
  logic              valid_i = 1'b0;
  logic [DW-1:0]     dat_o;
  logic              valid_o;
  logic [CBITS-1:0]  coeff_dat_i = '0;
  logic              coeff_wr_i = 1'b0;
  logic              coeff_update_i = 1'b0;
  logic              coeff_ack_o;
  logic              coeff_err_o;
  logic              coeff_err_clr_i = 1'b0;

  int n_cmp  = 0;
  int n_miss = 0;

  biquad_incremental_pipe dut (
    .clk             (clk),
    .rst             (rst),
    .dat_i           (dat_i),
    .y0_in           (y0_in),
    .y1_in           (y1_in),
    .valid_i         (valid_i),
    .dat_o           (dat_o),
    .valid_o         (valid_o),
    .coeff_dat_i     (coeff_dat_i),
    .coeff_wr_i      (coeff_wr_i),
    .coeff_update_i  (coeff_update_i),
    .coeff_ack_o     (coeff_ack_o),
    .coeff_err_o     (coeff_err_o),
    .coeff_err_clr_i (coeff_err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [NBITS-1:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < NSAMP; k++) r[NBITS*k +: NBITS] = v;
    return r;
  endfunction

  // Writes a full set, highest m first: even m gets c1, odd m gets c2.
  task automatic load_set(input logic [CBITS-1:0] c1, input logic [CBITS-1:0] c2);
    for (int m = NCOEF - 1; m >= 0; m--) begin
      coeff_dat_i = (m % 2 == 0) ? c1 : c2;
      coeff_wr_i  = 1'b1;
      step(1);
    end
    coeff_wr_i = 1'b0;
  endtask

  task automatic write_n(input int n, input logic [CBITS-1:0] v);
    for (int i = 0; i < n; i++) begin
      coeff_dat_i = v;
      coeff_wr_i  = 1'b1;
      step(1);
    end
    coeff_wr_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] x;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_dat", dat_o, '0);
    check("rst_valid", DW'(valid_o), '0);
    check("rst_ack", DW'(coeff_ack_o), '0);
    check("rst_err", DW'(coeff_err_o), '0);
    step(2);
    rst = 1'b0;

    // Passthrough with zero coefficients, x[k] = 400*k
    x = '0;
    for (int k = 0; k < NSAMP; k++) x[NBITS*k +: NBITS] = NBITS'(400 * k);
    dat_i = x; y0_in = 24'h123400; y1_in = 24'hABCD00; valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(6);
    check("pt_valid_early", DW'(valid_o), '0);
    step(1);
    check("pt_valid", DW'(valid_o), DW'(1));
    check("pt_dat", dat_o, {16'h0AF0, 16'h0960, 16'h07D0, 16'h0640,
                            16'h04B0, 16'h0320, 16'hABCD, 16'h1234});
    step(1);
    check("pt_valid_late", DW'(valid_o), '0);

    // Running sum: c1 = 1.0, c2 = 0
    load_set(ONE, 18'd0);
    coeff_update_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0;
    check("rs_ack", DW'(coeff_ack_o), DW'(1));
    check("rs_err", DW'(coeff_err_o), '0);
    step(1);
    check("rs_ack_pulse", DW'(coeff_ack_o), '0);
    dat_i = rep(16'd4); y0_in = '0; y1_in = '0; valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(7);
    check("rs_valid", DW'(valid_o), DW'(1));
    check("rs_dat", dat_o, {16'd24, 16'd20, 16'd16, 16'd12, 16'd8, 16'd4, 16'd0, 16'd0});

    // Frame coherence: old = running sum, new = zeros; update accepted at edge U
    load_set(18'd0, 18'd0);
    dat_i = rep(16'd4); y0_in = '0; y1_in = 24'h000100; valid_i = 1'b1;
    step(1);                       // frame A (U-1)
    coeff_update_i = 1'b1;
    step(1);                       // frame B at U
    coeff_update_i = 1'b0;
    check("coh_ack", DW'(coeff_ack_o), DW'(1));
    step(1);                       // frame C (U+1)
    step(1);                       // frame D (U+2)
    valid_i = 1'b0;
    step(3);
    check("coh_idle", DW'(valid_o), '0);
    step(1);
    check("coh_a_valid", DW'(valid_o), DW'(1));
    check("coh_a_old", dat_o, {16'd25, 16'd21, 16'd17, 16'd13, 16'd9, 16'd5, 16'd1, 16'd0});
    step(1);
    check("coh_b_old", dat_o, {16'd25, 16'd21, 16'd17, 16'd13, 16'd9, 16'd5, 16'd1, 16'd0});
    step(1);
    check("coh_c_new", dat_o, {16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd1, 16'd0});
    step(1);
    check("coh_d_new", dat_o, {16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd1, 16'd0});
    step(1);
    check("coh_end", DW'(valid_o), '0);

    // Protocol error: 5 writes then update, old (zero) set retained
    write_n(5, ONE);
    coeff_update_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0;
    check("perr_err", DW'(coeff_err_o), DW'(1));
    check("perr_noack", DW'(coeff_ack_o), '0);
    valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(7);
    check("perr_keep", dat_o, {16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd1, 16'd0});
    check("perr_err_sticky", DW'(coeff_err_o), DW'(1));
    coeff_err_clr_i = 1'b1;
    step(1);
    coeff_err_clr_i = 1'b0;
    check("perr_clr", DW'(coeff_err_o), '0);
    coeff_update_i = 1'b1; coeff_err_clr_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0; coeff_err_clr_i = 1'b0;
    check("perr_err_wins", DW'(coeff_err_o), DW'(1));
    coeff_err_clr_i = 1'b1;
    step(1);
    coeff_err_clr_i = 1'b0;
    check("perr_clr2", DW'(coeff_err_o), '0);

    // Write + update in READY: pre-shift set committed, write counted (cnt = 1)
    load_set(ONE, 18'd0);
    coeff_dat_i = 18'd0; coeff_wr_i = 1'b1; coeff_update_i = 1'b1;
    step(1);
    coeff_wr_i = 1'b0; coeff_update_i = 1'b0;
    check("wu_ack", DW'(coeff_ack_o), DW'(1));
    check("wu_err", DW'(coeff_err_o), '0);
    valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(7);
    check("wu_preshift", dat_o, {16'd25, 16'd21, 16'd17, 16'd13, 16'd9, 16'd5, 16'd1, 16'd0});
    write_n(NCOEF - 1, 18'd0);
    coeff_update_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0;
    check("wu_cnt1_ack", DW'(coeff_ack_o), DW'(1));
    check("wu_cnt1_err", DW'(coeff_err_o), '0);
    coeff_update_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0;
    check("commit_to_idle", DW'(coeff_err_o), DW'(1));
    coeff_err_clr_i = 1'b1;
    step(1);
    coeff_err_clr_i = 1'b0;

    // Overflow with c1 = 1.0, x[k] = 0x7FFF
    load_set(ONE, 18'd0);
    coeff_update_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0;
    step(1);
    dat_i = rep(16'h7FFF); y0_in = '0; y1_in = '0; valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(7);
    check("ovf_valid", DW'(valid_o), DW'(1));
`ifdef BIQUAD_INC_SAT_EN
    check("ovf_sat", dat_o, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                             16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000});
`else
    check("ovf_wrap", dat_o, {16'hFFFA, 16'h7FFB, 16'hFFFC, 16'h7FFD,
                              16'hFFFE, 16'h7FFF, 16'h0000, 16'h0000});
`endif

    // Reset mid-stream with sticky error and partial load pending
    coeff_update_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0;
    write_n(5, ONE);
    dat_i = rep(16'd4); valid_i = 1'b1;
    step(9);
    check("mid_pre_valid", DW'(valid_o), DW'(1));
    check("mid_pre_err", DW'(coeff_err_o), DW'(1));
    #2 rst = 1'b1; valid_i = 1'b0;
    #1;
    check("mid_rst_valid", DW'(valid_o), '0);
    check("mid_rst_dat", dat_o, '0);
    check("mid_rst_err", DW'(coeff_err_o), '0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("mid_no_stale", DW'(valid_o), '0);
    end
    write_n(7, ONE);
    coeff_update_i = 1'b1;
    step(1);
    coeff_update_i = 1'b0;
    check("mid_partial_err", DW'(coeff_err_o), DW'(1));
    check("mid_partial_noack", DW'(coeff_ack_o), '0);
    dat_i = rep(16'h1111); y0_in = 24'h222200; y1_in = 24'h333300; valid_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(6);
    check("post_valid_early", DW'(valid_o), '0);
    step(1);
    check("post_valid", DW'(valid_o), DW'(1));
    check("post_dat", dat_o, {16'h1111, 16'h1111, 16'h1111, 16'h1111,
                              16'h1111, 16'h1111, 16'h3333, 16'h2222});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule
